// File: rtl/quadrant_byte_sender.sv
// quadrant_byte_sender: streams header, one quadrant of buffer bytes in row-major order, then their checksum, over a UART start/done handshake.
module quadrant_byte_sender #(
  parameter int          LINHAS  = 4,
  parameter int          COLUNAS = 4,
  parameter int          ADDR_W  = 4,
  parameter logic [7:0]  HEADER  = 8'hAA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iniciar_i,
  input  logic [7:0]        dado_mem_i,
  input  logic              fim_tx_i,
  output logic [ADDR_W-1:0] endereco_o,
  output logic [7:0]        dado_tx_o,
  output logic              partida_tx_o,
  output logic              ocupado_o,
  output logic              pronto_o,
  output logic [3:0]        db_estado_o
);
  localparam int LW = LINHAS > 1 ? $clog2(LINHAS) : 1;
  localparam int CW = COLUNAS > 1 ? $clog2(COLUNAS) : 1;
  typedef enum logic [3:0] {
    INICIAL          = 4'd0,
    ENVIA_CABECALHO  = 4'd1,
    ESPERA_CABECALHO = 4'd2,
    LE_MEM           = 4'd3,
    ESPERA_MEM       = 4'd4,
    ENVIA_BYTE       = 4'd5,
    ESPERA_BYTE      = 4'd6,
    ATUALIZA         = 4'd7,
    ENVIA_CHECKSUM   = 4'd8,
    ESPERA_CHECKSUM  = 4'd9,
    FINAL            = 4'd10
  } state_t;
  state_t        state_q, state_d;
  logic [LW-1:0] linha_q, linha_d;
  logic [CW-1:0] coluna_q, coluna_d;
  logic [7:0]    soma_q, soma_d;
  logic [7:0]    dado_tx_q, dado_tx_d;
  logic          ultima_coluna, ultimo_byte;
  assign ultima_coluna = coluna_q == CW'(COLUNAS - 1);
  assign ultimo_byte   = ultima_coluna && linha_q == LW'(LINHAS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INICIAL;
      linha_q   <= '0;
      coluna_q  <= '0;
      soma_q    <= '0;
      dado_tx_q <= '0;
    end else begin
      state_q   <= state_d;
      linha_q   <= linha_d;
      coluna_q  <= coluna_d;
      soma_q    <= soma_d;
      dado_tx_q <= dado_tx_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    linha_d   = linha_q;
    coluna_d  = coluna_q;
    soma_d    = soma_q;
    dado_tx_d = dado_tx_q;
    case (state_q)
      INICIAL: if (iniciar_i) begin
        state_d   = ENVIA_CABECALHO;
        linha_d   = '0;
        coluna_d  = '0;
        soma_d    = '0;
        dado_tx_d = HEADER;
      end
      ENVIA_CABECALHO:  state_d = ESPERA_CABECALHO;
      ESPERA_CABECALHO: state_d = fim_tx_i ? LE_MEM : ESPERA_CABECALHO;
      LE_MEM:           state_d = ESPERA_MEM;
      ESPERA_MEM: begin
        state_d   = ENVIA_BYTE;
        dado_tx_d = dado_mem_i;
        soma_d    = soma_q + dado_mem_i;
      end
      ENVIA_BYTE:       state_d = ESPERA_BYTE;
      ESPERA_BYTE:      state_d = fim_tx_i ? ATUALIZA : ESPERA_BYTE;
      ATUALIZA: if (ultimo_byte) begin
        state_d   = ENVIA_CHECKSUM;
        dado_tx_d = soma_q;
      end else begin
        state_d  = LE_MEM;
        coluna_d = ultima_coluna ? '0 : coluna_q + CW'(1);
        linha_d  = ultima_coluna ? linha_q + LW'(1) : linha_q;
      end
      ENVIA_CHECKSUM:   state_d = ESPERA_CHECKSUM;
      ESPERA_CHECKSUM:  state_d = fim_tx_i ? FINAL : ESPERA_CHECKSUM;
      FINAL:            state_d = INICIAL;
      default:          state_d = INICIAL;
    endcase
  end
  assign endereco_o   = ADDR_W'(linha_q) * ADDR_W'(COLUNAS) + ADDR_W'(coluna_q);
  assign dado_tx_o    = dado_tx_q;
  assign partida_tx_o = state_q == ENVIA_CABECALHO || state_q == ENVIA_BYTE || state_q == ENVIA_CHECKSUM;
  assign pronto_o     = state_q == FINAL;
  assign ocupado_o    = state_q != INICIAL;
  // Encodings above FINAL are unreachable but flagged distinctly for debug.
  assign db_estado_o  = state_q > FINAL ? 4'hF : 4'(state_q);
endmodule
